ppi_strobed_port: RTL and testbench

PPI_STROBED_PORT -- requirements
Module: ppi_strobed_port

---
 rtl/ppi_strobed_port.sv | 200 ++++++++++++++++++++
 tb/tb_ppi_strobed_port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ppi_strobed_port.sv
// Single strobed 8255-style port: control-word decode, synchronised strobe/ack
// handshake, input/output latches and the IBF/OBF/INTR flag set.
module ppi_strobed_port #(
  parameter int DATA_W   = 8,
  parameter int INTE_BIT = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_word,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] port_in,
  output logic [DATA_W-1:0] port_out,
  output logic              port_oe,
  input  logic              stb_n,
  input  logic              ack_n,
  output logic              ibf,
  output logic              obf_n,
  output logic              intr,
  output logic [5:0]        status
);

  localparam logic [2:0] INTE_SEL = 3'(INTE_BIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FULL,
    ST_OBF,
    ST_WAIT_ACK_HI
  } state_e;

  state_e state_q, state_d;

  logic              dir_q, dir_d;
  logic [DATA_W-1:0] in_latch_q, in_latch_d;
  logic [DATA_W-1:0] out_latch_q, out_latch_d;
  logic              ibf_q, ibf_d;
  logic              obf_n_q, obf_n_d;
  logic              intr_q, intr_d;
  logic              inte_q, inte_d;
  logic              ovr_q, ovr_d;

  logic [1:0] stb_sync_q, ack_sync_q;
  logic       stb_prev_q, ack_prev_q;
  logic       stb_fall, stb_rise, ack_fall, ack_rise;
  logic       mode_set, bsr_inte;

  // Bits 6:5 of the control word carry no meaning for a single port.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_word[6:5];

  // Pins idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stb_sync_q <= 2'b11;
      ack_sync_q <= 2'b11;
      stb_prev_q <= 1'b1;
      ack_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // which is what turns this into a real two-stage shift chain.
      stb_sync_q <= {stb_sync_q[0], stb_n};
      ack_sync_q <= {ack_sync_q[0], ack_n};
      stb_prev_q <= stb_sync_q[1];
      ack_prev_q <= ack_sync_q[1];
    end
  end

  assign stb_fall = stb_prev_q & ~stb_sync_q[1];
  assign stb_rise = ~stb_prev_q & stb_sync_q[1];
  assign ack_fall = ack_prev_q & ~ack_sync_q[1];
  assign ack_rise = ~ack_prev_q & ack_sync_q[1];

  assign mode_set = cfg_valid & cfg_word[7];
  assign bsr_inte = cfg_valid & ~cfg_word[7] & (cfg_word[3:1] == INTE_SEL);

  // State register and all datapath/flag registers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      dir_q       <= 1'b1;
      in_latch_q  <= '0;
      out_latch_q <= '0;
      ibf_q       <= 1'b0;
      obf_n_q     <= 1'b1;
      intr_q      <= 1'b0;
      inte_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      in_latch_q  <= in_latch_d;
      out_latch_q <= out_latch_d;
      ibf_q       <= ibf_d;
      obf_n_q     <= obf_n_d;
      intr_q      <= intr_d;
      inte_q      <= inte_d;
      ovr_q       <= ovr_d;
    end
  end

  // Next-state logic; a control-word write pre-empts all port activity.
  always_comb begin
    // NOTE: every output of this block is given a hold default first, so no
    // path through the branches below can infer a latch.
    state_d     = state_q;
    dir_d       = dir_q;
    in_latch_d  = in_latch_q;
    out_latch_d = out_latch_q;
    ibf_d       = ibf_q;
    obf_n_d     = obf_n_q;
    intr_d      = intr_q;
    inte_d      = inte_q;
    ovr_d       = ovr_q;

    if (mode_set) begin
      state_d     = ST_IDLE;
      dir_d       = cfg_word[4];
      in_latch_d  = '0;
      out_latch_d = '0;
      ibf_d       = 1'b0;
      obf_n_d     = 1'b1;
      intr_d      = 1'b0;
      inte_d      = 1'b0;
      ovr_d       = 1'b0;
    end else if (cfg_valid) begin
      if (bsr_inte) begin
        inte_d = cfg_word[0];
      end
    end else if (dir_q) begin
      if (stb_rise && ibf_q && inte_q) begin
        intr_d = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (stb_fall) begin
            in_latch_d = port_in;
            ibf_d      = 1'b1;
            state_d    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (rd_en && stb_fall) begin
            // Old byte goes out on rd_data this cycle; the new one replaces it.
            in_latch_d = port_in;
          end else if (rd_en) begin
            ibf_d   = 1'b0;
            intr_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (stb_fall) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      if (wr_en) begin
        out_latch_d = wr_data;
        if (!obf_n_q) begin
          ovr_d = 1'b1;
        end
        obf_n_d = 1'b0;
        intr_d  = 1'b0;
        state_d = ST_OBF;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_OBF: begin
            if (ack_fall) begin
              obf_n_d = 1'b1;
              state_d = ST_WAIT_ACK_HI;
            end
          end
          ST_WAIT_ACK_HI: begin
            if (ack_rise) begin
              intr_d  = inte_q;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    port_oe  = ~dir_q;
    port_out = out_latch_q;
    rd_data  = dir_q ? in_latch_q : out_latch_q;
    ibf      = ibf_q;
    obf_n    = obf_n_q;
    intr     = intr_q;
    status   = {ovr_q, dir_q, inte_q, intr_q, ibf_q, ~obf_n_q};
  end

endmodule

// File: tb/tb_ppi_strobed_port.sv
// Directed bench for ppi_strobed_port: input and output handshakes, overrun,
// BSR decode, control-word priority and asynchronous reset.
module tb_ppi_strobed_port;

  logic       clk = 1'b0;
  logic       Reset;
  logic       cfg_valid;
  logic [7:0] cfg_word;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       port_oe;
  logic       stb_n;
  logic       ack_n;
  logic       ibf;
  logic       obf_n;
  logic       intr;
  logic [5:0] status;

  int n_checks = 0;
  int n_fail   = 0;

  ppi_strobed_port #(.DATA_W(8), .INTE_BIT(4)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .cfg_valid (cfg_valid),
    .cfg_word  (cfg_word),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .port_in   (port_in),
    .port_out  (port_out),
    .port_oe   (port_oe),
    .stb_n     (stb_n),
    .ack_n     (ack_n),
    .ibf       (ibf),
    .obf_n     (obf_n),
    .intr      (intr),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] w);
    cfg_valid = 1'b1;
    cfg_word  = w;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; cfg_valid = 1'b0; cfg_word = '0; wr_en = 1'b0; wr_data = '0;
    rd_en = 1'b0; port_in = '0; stb_n = 1'b1; ack_n = 1'b1;
    tick(2);
    check("rst_status", status, 6'b010000);
    check("rst_oe", port_oe, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_obf_n", obf_n, 1);
    Reset = 1'b0;
    tick(1);

    // Input handshake with interrupt enabled.
    cfg(8'h90);
    cfg(8'h09);
    check("in_cfg_status", status, 6'b011000);
    port_in = 8'hA5; stb_n = 1'b0;
    tick(2);
    check("ibf_before_3_edges", ibf, 0);
    tick(1);
    check("ibf_after_3_edges", ibf, 1);
    stb_n = 1'b1;
    tick(2);
    check("intr_before_rise", intr, 0);
    tick(1);
    check("intr_after_rise", intr, 1);
    rd_en = 1'b1;
    check("rd_data_a5", rd_data, 8'hA5);
    tick(1);
    rd_en = 1'b0;
    check("rd_clears_ibf_intr", {ibf, intr}, 2'b00);

    // Overrun: second strobe without a read keeps old data.
    stb_n = 1'b0; tick(3); stb_n = 1'b1; tick(3);
    port_in = 8'h3C; stb_n = 1'b0; tick(3);
    check("ovr_latch_kept", rd_data, 8'hA5);
    check("ovr_status", status, 6'b111110);
    stb_n = 1'b1; tick(3);
    cfg(8'h90);
    check("mode_set_clears", status, 6'b010000);
    check("mode_set_latch", rd_data, 0);

    // Same-cycle read and strobe fall in FULL.
    cfg(8'h09);
    port_in = 8'h11; stb_n = 1'b0; tick(3); stb_n = 1'b1; tick(3);
    port_in = 8'h22; stb_n = 1'b0; tick(2);
    rd_en = 1'b1;
    check("rd_fall_old_data", rd_data, 8'h11);
    tick(1);
    rd_en = 1'b0;
    check("rd_fall_ibf", ibf, 1);
    check("rd_fall_new_data", rd_data, 8'h22);
    check("rd_fall_no_ovr", status[5], 0);
    stb_n = 1'b1; tick(3);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    check("read_after_rd_fall", ibf, 0);

    // Read in IDLE changes nothing; ack edges are ignored in input mode.
    rd_en = 1'b1;
    check("idle_rd_data", rd_data, 8'h22);
    tick(1);
    rd_en = 1'b0;
    check("idle_rd_status", status, 6'b011000);
    ack_n = 1'b0; tick(3); ack_n = 1'b1; tick(3);
    check("in_mode_ack_ignored", status, 6'b011000);

    // Output handshake with interrupt enabled.
    cfg(8'h80);
    check("out_oe", port_oe, 1);
    cfg(8'h09);
    write(8'h5A);
    check("out_port_out", port_out, 8'h5A);
    check("out_obf_n_low", obf_n, 0);
    ack_n = 1'b0; tick(2);
    check("obf_before_fall", obf_n, 0);
    tick(1);
    check("obf_on_fall", obf_n, 1);
    ack_n = 1'b1; tick(2);
    check("out_intr_before_rise", intr, 0);
    tick(1);
    check("out_intr_on_rise", intr, 1);
    stb_n = 1'b0; tick(3); stb_n = 1'b1; tick(3);
    check("out_mode_stb_ignored", status, 6'b001100);

    // Overwrite while full sets ovr; write wins over a same-cycle ack fall.
    write(8'h5A);
    check("write_clears_intr", intr, 0);
    write(8'h66);
    check("overwrite_data", port_out, 8'h66);
    check("overwrite_ovr", status[5], 1);
    ack_n = 1'b0; tick(2);
    write(8'h77);
    check("wr_vs_ack_data", port_out, 8'h77);
    check("wr_vs_ack_obf", obf_n, 0);
    ack_n = 1'b1; tick(3);
    check("wr_vs_ack_still_obf", obf_n, 0);
    ack_n = 1'b0; tick(3);
    check("second_ack_fall", obf_n, 1);
    ack_n = 1'b1; tick(3);
    check("second_ack_intr", intr, 1);

    // Interrupt disabled: no intr; BSR on another select leaves inte alone.
    cfg(8'h80);
    write(8'h5A);
    ack_n = 1'b0; tick(3); ack_n = 1'b1; tick(3);
    check("inte0_no_intr", {intr, obf_n}, 2'b01);
    cfg(8'h07);
    check("bsr_sel3_inte0", status[3], 0);
    cfg(8'h09);
    cfg(8'h07);
    check("bsr_sel3_inte1", status[3], 1);

    // Control word beats a same-cycle write.
    wr_en = 1'b1; wr_data = 8'hC3;
    cfg(8'h80);
    wr_en = 1'b0;
    check("cfg_priority_data", port_out, 0);
    check("cfg_priority_obf", obf_n, 1);

    // Asynchronous reset between ack fall and rise.
    cfg(8'h09);
    write(8'hAB);
    ack_n = 1'b0; tick(3);
    check("pre_reset_obf", obf_n, 1);
    Reset = 1'b1;
    #1;
    check("async_rst_status", status, 6'b010000);
    check("async_rst_port_out", port_out, 0);
    check("async_rst_oe", port_oe, 0);
    tick(2);
    Reset = 1'b0;
    tick(3);
    ack_n = 1'b1;
    tick(4);
    check("post_reset_no_intr", status, 6'b010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
